// File: rtl/ibex_hpm_counter_bank_pkg.sv
// Shared definitions for the machine counter bank: CSR address bases,
// counter index type and the implemented-counter mask helper.
package ibex_hpm_counter_bank_pkg;

    // mcountinhibit shares its 0x320 slot with the base of the mhpmevent window
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_OFF_MHPMEVENT = 12'h320;
    localparam logic [11:0] CSR_OFF_MCOUNTER  = 12'hB00;
    localparam logic [11:0] CSR_OFF_MCOUNTERH = 12'hB80;
    // Each window is 32 entries, so the low five address bits select the index
    localparam logic [11:0] CSR_WINDOW_MASK   = 12'hFE0;

    localparam int unsigned HPM_MAX_COUNTERS = 29;

    typedef logic [4:0] hpm_cnt_idx_t;

    // Bit i set when counter index i exists: mcycle (0), minstret (2), HPM 3..num_hpm+2
    function automatic logic [31:0] impl_mask(input int unsigned num_hpm);
        logic [31:0] m;
        m = 32'h0000_0005;
        for (int unsigned i = 3; i < 32; i++) begin
            if (i < num_hpm + 3) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/ibex_hpm_counter_bank_counter.sv
// Single machine counter of configurable width with split lo/hi write
// access and a one-cycle wrap pulse. Output is zero-extended to 64 bits.
module ibex_counter #(
    parameter int CounterWidth = 32
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        counter_inc_i,
    input  logic        counterh_we_i,
    input  logic        counter_we_i,
    input  logic [31:0] counter_val_i,
    output logic [63:0] counter_val_o,
    output logic        counter_ovf_o
);

    // Bits at or above CounterWidth are forced to zero, which also drops
    // hi-half writes entirely when the counter is 32 bits or narrower.
    localparam logic [63:0] CntMask = (CounterWidth >= 64) ? {64{1'b1}}
                                                           : ((64'd1 << CounterWidth) - 64'd1);

    logic [63:0] r_cnt;
    logic        r_ovf;
    logic [63:0] w_next;
    logic        w_wr;
    logic        w_wrap;

    assign w_wr   = counter_we_i | counterh_we_i;
    // A write in the same cycle cancels the increment, so it can never wrap
    assign w_wrap = counter_inc_i & ~w_wr & (r_cnt == CntMask);

    // Next value: merge the written half(s), otherwise increment
    always_comb begin
        w_next = r_cnt;
        if (counter_we_i)  w_next[31:0]  = counter_val_i;
        if (counterh_we_i) w_next[63:32] = counter_val_i;
        if (!w_wr && counter_inc_i) w_next = r_cnt + 64'd1;
    end

    // Counter state and overflow pulse register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_cnt <= w_next & CntMask;
            r_ovf <= w_wrap;
        end
    end

    assign counter_val_o = r_cnt;
    assign counter_ovf_o = r_ovf;

endmodule

// File: rtl/ibex_hpm_counter_bank.sv
// Machine counter bank: mcycle, minstret and programmable HPM counters,
// with mhpmevent masks, mcountinhibit and the CSR decode/read mux.
module ibex_hpm_counter_bank
    import ibex_hpm_counter_bank_pkg::*;
#(
    parameter int MHPMCounterNum   = 10,
    parameter int MHPMCounterWidth = 40,
    parameter int NumEvents        = 16,
    parameter int CycleInstrWidth  = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 instr_ret_i,
    input  logic [NumEvents-1:0] events_i,
    input  logic [11:0]          csr_addr_i,
    input  logic                 csr_we_i,
    input  logic [31:0]          csr_wdata_i,
    output logic [31:0]          csr_rdata_o,
    output logic                 csr_hit_o,
    output logic [31:0]          counter_ovf_o
);

    localparam int unsigned NumHpm = (MHPMCounterNum > int'(HPM_MAX_COUNTERS)) ?
                                     HPM_MAX_COUNTERS : MHPMCounterNum;
    localparam logic [31:0] ImplMask = impl_mask(NumHpm);

    hpm_cnt_idx_t         w_idx;
    logic [11:0]          w_window;
    logic                 w_sel_lo;
    logic                 w_sel_hi;
    logic                 w_sel_inh;
    logic                 w_sel_evt;
    logic [31:0]          r_inhibit;
    logic [NumEvents-1:0] r_event [32];
    logic [63:0]          w_cnt_val [32];
    logic [31:0]          w_ovf;

    assign w_idx     = csr_addr_i[4:0];
    assign w_window  = csr_addr_i & CSR_WINDOW_MASK;
    assign w_sel_lo  = (w_window == CSR_OFF_MCOUNTER);
    assign w_sel_hi  = (w_window == CSR_OFF_MCOUNTERH);
    assign w_sel_inh = (csr_addr_i == CSR_MCOUNTINHIBIT);
    assign w_sel_evt = (w_window == CSR_OFF_MHPMEVENT) && (w_idx >= 5'd3);
    // Absent indices still hit so the CSR file does not trap on them
    assign csr_hit_o = w_sel_lo | w_sel_hi | w_sel_inh | w_sel_evt;

    // mcountinhibit: only implemented counter bits are stored
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_inhibit <= '0;
        end else if (csr_we_i && w_sel_inh) begin
            r_inhibit <= csr_wdata_i & ImplMask;
        end
    end

    // mhpmevent masks: written only for implemented HPM indices, truncated to NumEvents
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 32; i++) r_event[i] <= '0;
        end else if (csr_we_i && w_sel_evt && ImplMask[w_idx]) begin
            r_event[w_idx] <= NumEvents'(csr_wdata_i);
        end
    end

    for (genvar i = 0; i < 32; i++) begin : g_cnt
        if (ImplMask[i]) begin : g_impl
            logic w_inc;
            if (i == 0) begin : g_mcycle
                assign w_inc = ~r_inhibit[i];
            end else if (i == 2) begin : g_minstret
                assign w_inc = instr_ret_i & ~r_inhibit[i];
            end else begin : g_hpm
                assign w_inc = (|(r_event[i] & events_i)) & ~r_inhibit[i];
            end

            ibex_counter #(
                .CounterWidth((i < 3) ? CycleInstrWidth : MHPMCounterWidth)
            ) u_counter (
                .clk_i         (clk_i),
                .rst_ni        (rst_ni),
                .counter_inc_i (w_inc),
                .counterh_we_i (csr_we_i & w_sel_hi & (w_idx == hpm_cnt_idx_t'(i))),
                .counter_we_i  (csr_we_i & w_sel_lo & (w_idx == hpm_cnt_idx_t'(i))),
                .counter_val_i (csr_wdata_i),
                .counter_val_o (w_cnt_val[i]),
                .counter_ovf_o (w_ovf[i])
            );
        end else begin : g_absent
            assign w_cnt_val[i] = '0;
            assign w_ovf[i]     = 1'b0;
        end
    end

    assign counter_ovf_o = w_ovf;

    // Combinational read of the currently registered state
    always_comb begin
        csr_rdata_o = '0;
        if (w_sel_lo)       csr_rdata_o = w_cnt_val[w_idx][31:0];
        else if (w_sel_hi)  csr_rdata_o = w_cnt_val[w_idx][63:32];
        else if (w_sel_inh) csr_rdata_o = r_inhibit;
        else if (w_sel_evt) csr_rdata_o = 32'(r_event[w_idx]);
    end

endmodule

// File: tb/tb_ibex_hpm_counter_bank.sv
// Scoreboard bench for the counter bank: stimulus pushes expected values,
// a negedge monitor pops and compares whenever a read is presented.
module tb_ibex_hpm_counter_bank;

    localparam int NEV = 16;

    logic           clk_i = 1'b0;
    logic           rst_ni = 1'b0;
    logic           instr_ret_i = 1'b0;
    logic [NEV-1:0] events_i = '0;
    logic [11:0]    csr_addr_i = '0;
    logic           csr_we_i = 1'b0;
    logic [31:0]    csr_wdata_i = '0;
    logic [31:0]    csr_rdata_o;
    logic           csr_hit_o;
    logic [31:0]    counter_ovf_o;

    always #5 clk_i = ~clk_i;

    ibex_hpm_counter_bank #(
        .MHPMCounterNum   (2),
        .MHPMCounterWidth (40),
        .NumEvents        (NEV),
        .CycleInstrWidth  (64)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .instr_ret_i   (instr_ret_i),
        .events_i      (events_i),
        .csr_addr_i    (csr_addr_i),
        .csr_we_i      (csr_we_i),
        .csr_wdata_i   (csr_wdata_i),
        .csr_rdata_o   (csr_rdata_o),
        .csr_hit_o     (csr_hit_o),
        .counter_ovf_o (counter_ovf_o)
    );

    // kind: 0 = csr_rdata_o, 1 = csr_hit_o, 2 = counter_ovf_o
    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    logic sb_vld = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always @(negedge clk_i) begin
        exp_t        e;
        logic [31:0] act;
        if (sb_vld) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL monitor: read presented with no expected entry");
            end else begin
                e = sb_q.pop_front();
                case (e.kind)
                    1:       act = {31'b0, csr_hit_o};
                    2:       act = counter_ovf_o;
                    default: act = csr_rdata_o;
                endcase
                if (act !== e.exp) begin
                    failures++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic expect_val(input logic [11:0] addr, input logic [31:0] exp,
                              input int kind, input string nm);
        exp_t e;
        e.name = nm;
        e.kind = kind;
        e.exp  = exp;
        csr_addr_i = addr;
        sb_q.push_back(e);
        sb_vld = 1'b1;
        tick();
        sb_vld = 1'b0;
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] data);
        csr_addr_i  = addr;
        csr_wdata_i = data;
        csr_we_i    = 1'b1;
        tick();
        csr_we_i    = 1'b0;
    endtask

    task automatic pulse_ev(input int b, input int n);
        for (int k = 0; k < n; k++) begin
            events_i    = '0;
            events_i[b] = 1'b1;
            tick();
            events_i    = '0;
        end
    endtask

    initial begin
        tick();
        // Reset state while rst_ni is held low
        expect_val(12'hB00, 32'h0, 0, "rst_mcycle");
        expect_val(12'h320, 32'h0, 0, "rst_inhibit");
        expect_val(12'h323, 32'h0, 0, "rst_event3");
        expect_val(12'h000, 32'h0, 2, "rst_ovf");
        rst_ni = 1'b1;

        // 100 idle cycles
        repeat (100) tick();
        expect_val(12'hB00, 32'd100, 0, "idle_mcycle");
        expect_val(12'hB02, 32'h0, 0, "idle_minstret");
        expect_val(12'hB03, 32'h0, 0, "idle_hpm3");
        expect_val(12'hB80, 32'h0, 0, "idle_mcycleh");

        // minstret
        instr_ret_i = 1'b1;
        repeat (3) tick();
        instr_ret_i = 1'b0;
        expect_val(12'hB02, 32'd3, 0, "minstret_3");

        // Event mask and inhibit
        wr(12'h323, 32'h1);
        pulse_ev(0, 5);
        pulse_ev(1, 3);
        expect_val(12'hB03, 32'd5, 0, "hpm3_events");
        wr(12'h320, 32'h8);
        expect_val(12'h320, 32'h8, 0, "inhibit_rd");
        pulse_ev(0, 4);
        expect_val(12'hB03, 32'd5, 0, "hpm3_inhibited");
        wr(12'h320, 32'h0);

        // 40-bit wrap
        wr(12'hB83, 32'hFF);
        wr(12'hB03, 32'hFFFF_FFFE);
        expect_val(12'hB03, 32'hFFFF_FFFE, 0, "wrap_lo_wr");
        expect_val(12'hB83, 32'h0000_00FF, 0, "wrap_hi_wr");
        expect_val(12'h000, 32'h0, 2, "wr_no_ovf");
        pulse_ev(0, 1);
        expect_val(12'hB03, 32'hFFFF_FFFF, 0, "wrap_allones");
        pulse_ev(0, 1);
        expect_val(12'h000, 32'h8, 2, "ovf_pulse");
        expect_val(12'h000, 32'h0, 2, "ovf_cleared");
        expect_val(12'hB03, 32'h0, 0, "wrap_lo_zero");
        expect_val(12'hB83, 32'h0, 0, "wrap_hi_zero");

        // Write colliding with the mcycle increment
        wr(12'hB00, 32'h10);
        expect_val(12'hB00, 32'h10, 0, "collide_wr");
        expect_val(12'hB00, 32'h11, 0, "collide_next");

        // Absent counters, decode and register masking
        wr(12'hB07, 32'h55);
        wr(12'h327, 32'h1);
        expect_val(12'hB07, 32'h0, 0, "absent_cnt_rd");
        expect_val(12'hB07, 32'h1, 1, "absent_cnt_hit");
        expect_val(12'h327, 32'h0, 0, "absent_evt_rd");
        expect_val(12'h327, 32'h1, 1, "absent_evt_hit");
        expect_val(12'hB01, 32'h1, 1, "time_hit");
        expect_val(12'h321, 32'h0, 1, "nohit_321");
        expect_val(12'h300, 32'h0, 1, "nohit_300");
        wr(12'h320, 32'hFFFF_FFFF);
        expect_val(12'h320, 32'h1D, 0, "inhibit_mask");
        wr(12'h324, 32'hFFFF_FFFF);
        expect_val(12'h324, 32'h0000_FFFF, 0, "event_trunc");

        // Reset while a wrap pulse is live
        wr(12'h320, 32'h0);
        wr(12'hB83, 32'hFF);
        wr(12'hB03, 32'hFFFF_FFFF);
        pulse_ev(0, 1);
        rst_ni = 1'b0;
        expect_val(12'h000, 32'h0, 2, "midrst_ovf");
        rst_ni = 1'b1;
        expect_val(12'hB00, 32'h0, 0, "midrst_mcycle");
        expect_val(12'h323, 32'h0, 0, "midrst_event3");
        expect_val(12'h320, 32'h0, 0, "midrst_inhibit");
        expect_val(12'hB03, 32'h0, 0, "midrst_hpm3");
        expect_val(12'hB83, 32'h0, 0, "midrst_hpm3h");
        expect_val(12'hB02, 32'h0, 0, "midrst_minstret");

        // Drain the scoreboard within a bounded number of cycles
        for (int k = 0; k < 10 && sb_q.size() != 0; k++) tick();
        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d entries left expected 0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
